// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and a selectable first-word-fall-through read port.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         w_ptr_q, w_ptr_d;
  logic [PW-1:0]         r_ptr_q, r_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full_s, empty_s;
  logic                  wr_ok_s, rd_ok_s;

  // Explicit modulo-depth wrap so non-power-of-two depths never alias.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(FIFO_DEPTH - 1)) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // Status decode straight from the registered count.
  always_comb begin
    full_s  = (count_q == CW'(FIFO_DEPTH));
    empty_s = (count_q == {CW{1'b0}});
    wr_ok_s = we & ~full_s;
    rd_ok_s = re & ~empty_s;
  end

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (wr_ok_s) begin
      w_ptr_d = ptr_inc(w_ptr_q);
    end else begin
      w_ptr_d = w_ptr_q;
    end
    if (rd_ok_s) begin
      r_ptr_d = ptr_inc(r_ptr_q);
    end else begin
      r_ptr_d = r_ptr_q;
    end
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new error event outranks a simultaneous clear.
    if (we & full_s) begin
      ovf_d = 1'b1;
    end else if (clr_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (re & empty_s) begin
      udf_d = 1'b1;
    end else if (clr_err) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_ptr_q <= {PW{1'b0}};
      r_ptr_q <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; contents survive reset, writes in the reset cycle are suppressed.
  always_ff @(posedge clk) begin
    if (rst && wr_ok_s) begin
      mem_q[w_ptr_q] <= din;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      always_comb begin
        dout       = mem_q[r_ptr_q];
        dout_valid = ~empty_s;
      end
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q, dout_d;
      logic                  dv_q, dv_d;

      // Registered read port: capture the head word on an accepted pop.
      always_comb begin
        dout_d = dout_q;
        dv_d   = 1'b0;
        if (rd_ok_s) begin
          dout_d = mem_q[r_ptr_q];
          dv_d   = 1'b1;
        end else begin
          dout_d = dout_q;
          dv_d   = 1'b0;
        end
      end

      // Read data register.
      always_ff @(posedge clk) begin
        if (!rst) begin
          dout_q <= {DATA_WIDTH{1'b0}};
          dv_q   <= 1'b0;
        end else begin
          dout_q <= dout_d;
          dv_q   <= dv_d;
        end
      end

      always_comb begin
        dout       = dout_q;
        dout_valid = dv_q;
      end
    end
  endgenerate

  // Output drive.
  always_comb begin
    full         = full_s;
    empty        = empty_s;
    almost_full  = (count_q >= CW'(AF_THRESH));
    almost_empty = (count_q <= CW'(AE_THRESH));
    count        = count_q;
    overflow     = ovf_q;
    underflow    = udf_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: three sync_fifo instances (depth 5 std, depth 8 std, depth 4 FWFT)
// checked every cycle against a queue-style model plus hand-computed literal pins.
module tb_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s;
  logic       we_s [3];
  logic       re_s [3];
  logic       clr_s [3];
  logic [7:0] din_s [3];

  logic [7:0] dout_s [3];
  logic       dv_s [3];
  logic       full_s [3];
  logic       empty_s [3];
  logic       af_s [3];
  logic       ae_s [3];
  logic       ovf_s [3];
  logic       udf_s [3];
  logic [2:0] cnt0_s;
  logic [3:0] cnt1_s;
  logic [2:0] cnt2_s;

  sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .AF_THRESH(3), .AE_THRESH(2), .FWFT(1'b0)) u0 (
    .clk(clk), .rst(rst_s), .we(we_s[0]), .din(din_s[0]), .re(re_s[0]),
    .dout(dout_s[0]), .dout_valid(dv_s[0]), .full(full_s[0]), .empty(empty_s[0]),
    .almost_full(af_s[0]), .almost_empty(ae_s[0]), .count(cnt0_s),
    .clr_err(clr_s[0]), .overflow(ovf_s[0]), .underflow(udf_s[0]));

  sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0)) u1 (
    .clk(clk), .rst(rst_s), .we(we_s[1]), .din(din_s[1]), .re(re_s[1]),
    .dout(dout_s[1]), .dout_valid(dv_s[1]), .full(full_s[1]), .empty(empty_s[1]),
    .almost_full(af_s[1]), .almost_empty(ae_s[1]), .count(cnt1_s),
    .clr_err(clr_s[1]), .overflow(ovf_s[1]), .underflow(udf_s[1]));

  sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .AF_THRESH(2), .AE_THRESH(2), .FWFT(1'b1)) u2 (
    .clk(clk), .rst(rst_s), .we(we_s[2]), .din(din_s[2]), .re(re_s[2]),
    .dout(dout_s[2]), .dout_valid(dv_s[2]), .full(full_s[2]), .empty(empty_s[2]),
    .almost_full(af_s[2]), .almost_empty(ae_s[2]), .count(cnt2_s),
    .clr_err(clr_s[2]), .overflow(ovf_s[2]), .underflow(udf_s[2]));

  int depth_c [3] = '{5, 8, 4};
  int af_c    [3] = '{3, 6, 2};
  int ae_c    [3] = '{2, 2, 2};
  int fwft_c  [3] = '{0, 0, 1};

  // Model: every word ever written gets a sequence number; occupancy is writes minus reads.
  int         wn [3];
  int         rn [3];
  logic [7:0] data_m [3][256];
  bit         ovf_m [3];
  bit         udf_m [3];
  bit         dv_m [3];
  logic [7:0] dout_m [3];

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int cnt_of(input int k);
    if (k == 0) return int'(cnt0_s);
    else if (k == 1) return int'(cnt1_s);
    else return int'(cnt2_s);
  endfunction

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int  occ;
      bit  wok, rok, isfull, isempty;
      occ     = wn[k] - rn[k];
      isfull  = (occ == depth_c[k]);
      isempty = (occ == 0);
      if (!rst_s) begin
        wn[k] = 0; rn[k] = 0; ovf_m[k] = 0; udf_m[k] = 0; dv_m[k] = 0; dout_m[k] = 8'h00;
      end else begin
        wok = we_s[k] && !isfull;
        rok = re_s[k] && !isempty;
        dv_m[k] = rok;
        if (rok) dout_m[k] = data_m[k][rn[k] % 256];
        if (wok) begin
          data_m[k][wn[k] % 256] = din_s[k];
          wn[k]++;
        end
        if (rok) rn[k]++;
        if (we_s[k] && isfull) ovf_m[k] = 1;
        else if (clr_s[k]) ovf_m[k] = 0;
        if (re_s[k] && isempty) udf_m[k] = 1;
        else if (clr_s[k]) udf_m[k] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        int occ;
        occ = wn[k] - rn[k];
        chk($sformatf("k%0d count", k), cnt_of(k), occ);
        chk($sformatf("k%0d full", k), int'(full_s[k]), int'(occ == depth_c[k]));
        chk($sformatf("k%0d empty", k), int'(empty_s[k]), int'(occ == 0));
        chk($sformatf("k%0d almost_full", k), int'(af_s[k]), int'(occ >= af_c[k]));
        chk($sformatf("k%0d almost_empty", k), int'(ae_s[k]), int'(occ <= ae_c[k]));
        chk($sformatf("k%0d overflow", k), int'(ovf_s[k]), int'(ovf_m[k]));
        chk($sformatf("k%0d underflow", k), int'(udf_s[k]), int'(udf_m[k]));
        if (fwft_c[k] != 0) begin
          chk($sformatf("k%0d dout_valid", k), int'(dv_s[k]), int'(occ > 0));
          if (occ > 0) chk($sformatf("k%0d dout", k), int'(dout_s[k]), int'(data_m[k][rn[k] % 256]));
        end else begin
          chk($sformatf("k%0d dout_valid", k), int'(dv_s[k]), int'(dv_m[k]));
          chk($sformatf("k%0d dout", k), int'(dout_s[k]), int'(dout_m[k]));
        end
      end
    end
  end

  initial begin
    rst_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      we_s[k] = 1'b0; re_s[k] = 1'b0; clr_s[k] = 1'b0; din_s[k] = 8'h00;
      wn[k] = 0; rn[k] = 0; ovf_m[k] = 0; udf_m[k] = 0; dv_m[k] = 0; dout_m[k] = 8'h00;
    end
    tick(); tick();
    rst_s = 1'b1;
    chk_en = 1'b1;
    chk("rst count", int'(cnt0_s), 0);
    chk("rst empty", int'(empty_s[0]), 1);
    chk("rst almost_empty", int'(ae_s[0]), 1);
    chk("rst almost_full", int'(af_s[0]), 0);
    chk("rst dout_valid", int'(dv_s[0]), 0);
    chk("rst dout", int'(dout_s[0]), 0);

    // Fill and drain, with an overflow while full.
    for (int i = 0; i < 5; i++) begin
      we_s[0] = 1'b1; din_s[0] = 8'h10 + 8'(i); tick();
    end
    chk("fill full", int'(full_s[0]), 1);
    chk("fill count", int'(cnt0_s), 5);
    din_s[0] = 8'h99; tick();
    chk("ovf set", int'(ovf_s[0]), 1);
    chk("ovf count", int'(cnt0_s), 5);
    we_s[0] = 1'b0; re_s[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("drain dout", int'(dout_s[0]), 'h10 + i);
      chk("drain valid", int'(dv_s[0]), 1);
    end
    re_s[0] = 1'b0; tick();
    chk("drained valid", int'(dv_s[0]), 0);
    chk("drained empty", int'(empty_s[0]), 1);
    re_s[0] = 1'b1; tick();
    chk("udf set", int'(udf_s[0]), 1);
    chk("udf valid", int'(dv_s[0]), 0);
    re_s[0] = 1'b0; clr_s[0] = 1'b1; tick();
    chk("clr ovf", int'(ovf_s[0]), 0);
    chk("clr udf", int'(udf_s[0]), 0);
    clr_s[0] = 1'b0;

    // Non-power-of-two wrap: interleaved write/read pairs.
    for (int i = 0; i < 12; i++) begin
      we_s[0] = 1'b1; din_s[0] = 8'(i); tick();
      we_s[0] = 1'b0; re_s[0] = 1'b1; tick();
      chk("wrap dout", int'(dout_s[0]), i);
      re_s[0] = 1'b0;
    end

    // Sustained simultaneous write and read at occupancy 1.
    we_s[0] = 1'b1; din_s[0] = 8'h30; tick();
    re_s[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din_s[0] = 8'h40 + 8'(i); tick();
      chk("stream dout", int'(dout_s[0]), (i == 0) ? 'h30 : 'h40 + i - 1);
    end
    we_s[0] = 1'b0; tick();
    chk("stream last", int'(dout_s[0]), 'h45);
    re_s[0] = 1'b0;

    // Full with we and re: read accepted, write dropped.
    for (int i = 0; i < 5; i++) begin
      we_s[0] = 1'b1; din_s[0] = 8'h50 + 8'(i); tick();
    end
    re_s[0] = 1'b1; din_s[0] = 8'hEE; tick();
    chk("full rw count", int'(cnt0_s), 4);
    chk("full rw ovf", int'(ovf_s[0]), 1);
    chk("full rw dout", int'(dout_s[0]), 'h50);
    we_s[0] = 1'b0;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("full rw drain", int'(dout_s[0]), 'h50 + i);
    end
    re_s[0] = 1'b0; clr_s[0] = 1'b1; tick(); clr_s[0] = 1'b0;

    // Thresholds on the depth-8 instance.
    for (int i = 0; i < 6; i++) begin
      we_s[1] = 1'b1; din_s[1] = 8'h20 + 8'(i); tick();
      if (i == 1) chk("ae after 2", int'(ae_s[1]), 1);
      if (i == 2) chk("ae after 3", int'(ae_s[1]), 0);
      if (i == 4) chk("af after 5", int'(af_s[1]), 0);
      if (i == 5) chk("af after 6", int'(af_s[1]), 1);
    end
    we_s[1] = 1'b0; re_s[1] = 1'b1; tick();
    chk("af after read", int'(af_s[1]), 0);
    chk("thr dout", int'(dout_s[1]), 'h20);
    re_s[1] = 1'b0;

    // FWFT instance.
    we_s[2] = 1'b1; din_s[2] = 8'hA5; tick();
    we_s[2] = 1'b0;
    chk("fwft dout", int'(dout_s[2]), 'hA5);
    chk("fwft valid", int'(dv_s[2]), 1);
    re_s[2] = 1'b1; tick();
    chk("fwft empty", int'(empty_s[2]), 1);
    chk("fwft valid off", int'(dv_s[2]), 0);
    we_s[2] = 1'b1; din_s[2] = 8'h5A; tick();
    chk("fwft empty rw count", int'(cnt2_s), 1);
    chk("fwft empty rw udf", int'(udf_s[2]), 1);
    chk("fwft empty rw dout", int'(dout_s[2]), 'h5A);
    we_s[2] = 1'b0; tick();
    re_s[2] = 1'b0; clr_s[2] = 1'b1; tick(); clr_s[2] = 1'b0;

    // Reset mid-stream with three words stored and we=re=1.
    for (int i = 0; i < 3; i++) begin
      we_s[0] = 1'b1; din_s[0] = 8'h61 + 8'(i); tick();
    end
    re_s[0] = 1'b1; din_s[0] = 8'h64; rst_s = 1'b0; tick();
    rst_s = 1'b1; we_s[0] = 1'b0; re_s[0] = 1'b0;
    chk("mid rst count", int'(cnt0_s), 0);
    chk("mid rst empty", int'(empty_s[0]), 1);
    chk("mid rst valid", int'(dv_s[0]), 0);
    chk("mid rst ovf", int'(ovf_s[0]), 0);
    chk("mid rst udf", int'(udf_s[0]), 0);
    chk("mid rst k1 count", int'(cnt1_s), 0);
    we_s[0] = 1'b1; din_s[0] = 8'h77; tick();
    we_s[0] = 1'b0; re_s[0] = 1'b1; tick();
    chk("post rst dout", int'(dout_s[0]), 'h77);
    chk("post rst valid", int'(dv_s[0]), 1);
    re_s[0] = 1'b0; tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
